imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writes a program into the CPU's word-addressed instruction memory. It receives the image as a byte stream,
//  assembles 32-bit words, checks the image, and holds the CPU in reset until the image is good.
//  It sits between a host byte link (UART RX or debug port) and the instruction RAM write port. The CPU fetch path
//  reads that RAM by PC, which is word-addressed (PC+1 per instruction).
// PARAMETERS
//  ADDR_W   8   instruction memory word-address width; max image = 2**ADDR_W words
// PORTS
//  clk        in   1       system clock, single clock domain
//  reset      in   1       synchronous, active-high reset
//  rx_data    in   8       incoming byte
//  rx_valid   in   1       rx_data valid
//  rx_ready   out  1       loader accepts byte; transfer when rx_valid && rx_ready
//  load_req   in   1       1-cycle pulse: start or restart a load
//  mem_we     out  1       instruction RAM write enable, 1-cycle pulse per word
//  mem_addr   out  ADDR_W  instruction RAM word address
//  mem_wdata  out  32      instruction word
//  cpu_reset  out  1       reset to CPU core; 1 = CPU held
//  busy       out  1       load in progress
//  done       out  1       image loaded and verified; CPU running
//  err        out  1       last load failed (bad length or checksum)
// BEHAVIOUR
//  Frame format, big-endian:
//   - LEN_HI, LEN_LO: word count N, 16 bits
//   - N*4 data bytes, each word sent MSB first
//   - CHK: XOR of all data bytes; header bytes are excluded
//  Reset: state=IDLE. mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, rx_ready=0, busy=0, done=0, err=0.
//  All outputs are registered.
//  States:
//   - IDLE:   load_req -> LEN_HI.
//   - LEN_HI: accept byte -> LEN_LO.
//   - LEN_LO: accept byte, then
//       N==0 or N>2**ADDR_W -> ERROR;
//       otherwise -> DATA with word index=0, byte count=0, chk=0.
//   - DATA:   each accepted byte: shift_reg <= {shift_reg[23:0],rx_data}, chk ^= rx_data.
//       On the 4th byte of a word, the next cycle drives mem_we=1 (one cycle),
//       mem_addr=word index, mem_wdata=assembled word. The word index then increments.
//       After word N-1's 4th byte -> CHK.
//   - CHK:    accept byte.
//       Equal to chk -> RUN: done=1 and cpu_reset=0 from the next cycle.
//       Not equal -> ERROR: err=1, cpu_reset stays 1.
//   - RUN:    CPU runs. load_req -> LEN_HI, with cpu_reset=1 and done=0 the next cycle.
//   - ERROR:  err held. load_req -> LEN_HI, err cleared.
//  rx_ready=1 only in LEN_HI, LEN_LO, DATA, CHK. busy=1 in the same states.
//  rx_ready never depends on rx_valid in the same cycle.
//  At most one byte is accepted per cycle. Back-to-back bytes every cycle are supported;
//  mem_we may then pulse once every 4 cycles.
//  Boundary conditions:
//   - load_req while busy: restart at LEN_HI. A byte accepted in that same cycle is consumed and discarded.
//     A write already registered for the next cycle still issues.
//   - load_req in LEN_HI with a byte: the byte is discarded and state stays LEN_HI.
//   - N==2**ADDR_W: allowed; last write at mem_addr=2**ADDR_W-1, no wrap.
//   - reset mid-load: immediate return to reset values; a pending mem_we is cancelled.
//   - mem_addr and mem_wdata hold their last values when mem_we=0.
// TESTING
//  1. Frame 00 01 | 12 34 56 78 | 08 -> one mem_we at addr 0 with 0x12345678;
//     done=1, cpu_reset=0 the cycle after CHK.
//  2. Frame 00 03, words 0x20010005,0x20020003,0x00221820, then correct CHK ->
//     writes at addr 0,1,2 in order; done=1.
//  3. Same as 1 with CHK=0x09 -> err=1, done=0, cpu_reset=1;
//     then load_req plus a good frame -> err=0, done=1.
//  4. LEN=0x0000 -> ERROR after LEN_LO, no mem_we.
//     LEN=0x0101 with ADDR_W=8 -> ERROR, no mem_we.
//  5. load_req after 2 of 4 words, then a new 1-word frame -> cpu_reset=1 during the reload;
//     only the new frame's checksum is used; done=1.
//  6. reset asserted the cycle after a word's 4th byte -> no mem_we;
//     all outputs at reset values next cycle; rx_valid held high is not accepted in IDLE.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
// Receives a program image as a byte stream, assembles big-endian 32-bit
// words, writes them into the word-addressed instruction RAM and verifies an
// XOR checksum. The CPU is held in reset until a frame has been accepted.
//
// Frame: LEN_HI, LEN_LO (word count N), N*4 data bytes (MSB first), CHK.
// CHK is the XOR of the data bytes only.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   rx_data/rx_valid    incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready
//   load_req            one-cycle pulse: start or restart a load
//   mem_we/addr/wdata   instruction RAM write port (one pulse per word)
//   cpu_reset           1 holds the CPU core in reset
//   busy                a load is in progress
//   done                image loaded and verified, CPU running
//   err                 last load failed (bad length or checksum)
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    state_t            state_r;
    logic [7:0]        len_hi_r;
    logic [ADDR_W-1:0] word_idx_r;
    logic [ADDR_W-1:0] last_idx_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [1:0]        byte_cnt_r;
    logic [31:0]       shift_r;
    logic [7:0]        chk_r;
    logic              pend_r;

    logic              accept_s;
    logic [15:0]       len_s;
    logic              len_bad_s;
    logic [ADDR_W-1:0] len_last_s;

    // Running image checksum: XOR of every data byte.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // rx_ready is a register, so the handshake never loops back through rx_valid.
    assign accept_s   = rx_valid & rx_ready;
    // Word count as seen while the LEN_LO byte is on rx_data.
    assign len_s      = {len_hi_r, rx_data};
    assign len_bad_s  = (len_s == 16'd0) || ({1'b0, len_s} > MAX_WORDS);
    // N-1 fits in ADDR_W bits for every legal N (N == 2**ADDR_W gives all ones).
    assign len_last_s = len_s[ADDR_W-1:0] - ONE_A;

    // Load sequencer: state, byte assembly, checksum, write stage and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= ZERO_A;
            mem_wdata   <= 32'h0000_0000;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            len_hi_r    <= 8'h00;
            word_idx_r  <= ZERO_A;
            last_idx_r  <= ZERO_A;
            pend_addr_r <= ZERO_A;
            byte_cnt_r  <= 2'd0;
            shift_r     <= 32'h0000_0000;
            chk_r       <= 8'h00;
            pend_r      <= 1'b0;
        end else begin
            // Write stage: a word completed last cycle is issued now, even if a
            // restart arrives in this cycle. Address/data hold when idle.
            mem_we <= pend_r;
            if (pend_r) begin
                mem_addr  <= pend_addr_r;
                mem_wdata <= shift_r;
            end
            pend_r <= 1'b0;

            if (load_req) begin
                // Restart from any state; a byte taken this cycle is dropped.
                state_r   <= ST_LEN_HI;
                rx_ready  <= 1'b1;
                busy      <= 1'b1;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
            end else begin
                case (state_r)
                    ST_LEN_HI: begin
                        if (accept_s) begin
                            len_hi_r <= rx_data;
                            state_r  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (accept_s) begin
                            if (len_bad_s) begin
                                state_r  <= ST_ERROR;
                                err      <= 1'b1;
                                rx_ready <= 1'b0;
                                busy     <= 1'b0;
                            end else begin
                                state_r    <= ST_DATA;
                                word_idx_r <= ZERO_A;
                                last_idx_r <= len_last_s;
                                byte_cnt_r <= 2'd0;
                                chk_r      <= 8'h00;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (accept_s) begin
                            shift_r    <= {shift_r[23:0], rx_data};
                            chk_r      <= chk_update(chk_r, rx_data);
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            if (byte_cnt_r == 2'd3) begin
                                pend_r      <= 1'b1;
                                pend_addr_r <= word_idx_r;
                                word_idx_r  <= word_idx_r + ONE_A;
                                if (word_idx_r == last_idx_r) begin
                                    state_r <= ST_CHK;
                                end
                            end
                        end
                    end
                    ST_CHK: begin
                        if (accept_s) begin
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            if (rx_data == chk_r) begin
                                state_r   <= ST_RUN;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                state_r <= ST_ERROR;
                                err     <= 1'b1;
                            end
                        end
                    end
                    ST_IDLE, ST_RUN, ST_ERROR: begin
                        // Wait for load_req; outputs hold.
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        rx_ready  <= 1'b0;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
